// File: rtl/pineball_pkg.sv
// Shared types and default geometry for the pineball sprite.
// The renderer imports the same SIZE so the drawn box matches the collision box.
package pineball_pkg;

  localparam int H_DISP_DEF = 640;
  localparam int V_DISP_DEF = 480;
  localparam int SIZE_DEF   = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STEP_X = 2'd2,
    ST_STEP_Y = 2'd3
  } state_t;

  // dir = 0 moves toward larger coordinates, dir = 1 toward smaller ones
  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       hit;
  } axis_t;

  function automatic axis_t axis_step(input logic [9:0] pos, input logic dir,
                                      input logic [2:0] speed, input logic [9:0] pmax);
    axis_t      res;
    logic [10:0] sum;
    res.pos = pos;
    res.dir = dir;
    res.hit = 1'b0;
    sum     = {1'b0, pos} + {8'd0, speed};
    if (speed == 3'd0) begin
      res.pos = pos;
    end else if (dir == 1'b0) begin
      if (sum >= {1'b0, pmax}) begin
        res.pos = pmax;
        res.dir = 1'b1;
        res.hit = 1'b1;
      end else begin
        res.pos = sum[9:0];
      end
    end else begin
      if (pos <= {7'd0, speed}) begin
        res.pos = 10'd0;
        res.dir = 1'b0;
        res.hit = 1'b1;
      end else begin
        res.pos = pos - {7'd0, speed};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pineball_motion_ctrl_frame_tick_gen.sv
// Detects the first line of vertical blanking and divides frames down
// to motion steps; step_req is a single-cycle request.
module frame_tick_gen
  import pineball_pkg::*;
#(
  parameter int V_DISP    = V_DISP_DEF,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       run,
  input  logic [9:0] vga_ypos,
  output logic       step_req
);

  logic       eq;
  logic       eq_q;
  logic       tick;
  logic       last;
  logic [3:0] div;

  assign eq       = (vga_ypos == 10'(V_DISP));
  assign tick     = eq & ~eq_q;
  assign last     = (div == 4'(FRAME_DIV - 1));
  assign step_req = tick & run & last & ~clear;

  // Edge register and divider; divider freezes while run is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eq_q <= 1'b0;
      div  <= 4'd0;
    end else begin
      eq_q <= eq;
      if (clear) begin
        div <= 4'd0;
      end else if (tick && run) begin
        div <= last ? 4'd0 : div + 4'd1;
      end else begin
        div <= div;
      end
    end
  end

endmodule

// File: rtl/pineball_motion_ctrl.sv
// Ball position owner: steps x then y once per divided frame during
// vertical blanking and reflects off the screen edges.
module pineball_motion_ctrl
  import pineball_pkg::*;
#(
  parameter int H_DISP    = H_DISP_DEF,
  parameter int V_DISP    = V_DISP_DEF,
  parameter int SIZE      = SIZE_DEF,
  parameter int FRAME_DIV = 1,
  parameter int INIT_X    = 320,
  parameter int INIT_Y    = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] vga_ypos,
  input  logic       run,
  input  logic       serve,
  input  logic [2:0] speed_x,
  input  logic [2:0] speed_y,
  output logic [9:0] pineball_x,
  output logic [9:0] pineball_y,
  output logic       bounce_x,
  output logic       bounce_y
);

  localparam logic [9:0] XMAX = 10'(H_DISP - 1 - SIZE);
  localparam logic [9:0] YMAX = 10'(V_DISP - 1 - SIZE);

  state_t state;
  state_t state_next;
  logic   step_req;
  logic   dir_x;
  logic   dir_y;
  axis_t  ax;
  axis_t  ay;

  frame_tick_gen #(
    .V_DISP   (V_DISP),
    .FRAME_DIV(FRAME_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (serve),
    .run     (run),
    .vga_ypos(vga_ypos),
    .step_req(step_req)
  );

  assign ax = axis_step(pineball_x, dir_x, speed_x, XMAX);
  assign ay = axis_step(pineball_y, dir_y, speed_y, YMAX);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state; serve overrides whatever step was in flight
  always_comb begin
    state_next = state;
    if (serve) begin
      state_next = run ? ST_WAIT : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_next = run ? ST_WAIT : ST_IDLE;
        ST_WAIT: begin
          if (step_req) begin
            state_next = ST_STEP_X;
          end else if (!run) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_WAIT;
          end
        end
        ST_STEP_X: state_next = ST_STEP_Y;
        ST_STEP_Y: state_next = run ? ST_WAIT : ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // Axis updates and bounce pulses
  always_ff @(posedge clk) begin
    if (!rst_n || serve) begin
      pineball_x <= 10'(INIT_X);
      pineball_y <= 10'(INIT_Y);
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      bounce_x   <= 1'b0;
      bounce_y   <= 1'b0;
    end else begin
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      if (state == ST_STEP_X) begin
        pineball_x <= ax.pos;
        dir_x      <= ax.dir;
        bounce_x   <= ax.hit;
      end
      if (state == ST_STEP_Y) begin
        pineball_y <= ay.pos;
        dir_y      <= ay.dir;
        bounce_y   <= ay.hit;
      end
    end
  end

endmodule

// File: tb/tb_pineball_motion_ctrl.sv
// Bench for pineball_motion_ctrl: two instances (FRAME_DIV 1 and 3) checked
// every cycle against a pending-update reference model, plus pinned values.
module tb_pineball_motion_ctrl;

  localparam int XM = 634;
  localparam int YM = 474;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       serve;
  logic [2:0] sx;
  logic [2:0] sy;
  logic [9:0] ypos;
  logic [9:0] px [2];
  logic [9:0] py [2];
  logic       bx [2];
  logic       by [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int fc = 5;

  int fd [2] = '{1, 3};
  int m_x [2], m_y [2], m_dx [2], m_dy [2], m_div [2];
  int m_ar [2], m_xd [2], m_yd [2], m_bx [2], m_by [2];
  bit m_eqq;

  always #5 clk = ~clk;

  pineball_motion_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .vga_ypos(ypos), .run(run), .serve(serve),
    .speed_x(sx), .speed_y(sy), .pineball_x(px[0]), .pineball_y(py[0]),
    .bounce_x(bx[0]), .bounce_y(by[0])
  );

  pineball_motion_ctrl #(.FRAME_DIV(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .vga_ypos(ypos), .run(run), .serve(serve),
    .speed_x(sx), .speed_y(sy), .pineball_x(px[1]), .pineball_y(py[1]),
    .bounce_x(bx[1]), .bounce_y(by[1])
  );

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reflecting walk along one axis in signed integer terms
  function automatic void move(input int p, input int d, input int s, input int mx,
                               output int np, output int nd, output int b);
    np = p; nd = d; b = 0;
    if (s != 0) begin
      np = p + d * s;
      if (np >= mx) begin
        np = mx; nd = -1; b = 1;
      end else if (np <= 0) begin
        np = 0; nd = 1; b = 1;
      end
    end
  endfunction

  // Reference: a step request makes x due next cycle, then y the cycle after
  always @(posedge clk) begin : model
    bit tk;
    tk = (ypos == 10'd480) && !m_eqq;
    m_eqq <= rst_n ? (ypos == 10'd480) : 1'b0;
    for (int i = 0; i < 2; i++) begin
      int x, y, dx, dy, dv, ar, xd, yd, b1, b2;
      bit stp;
      x = m_x[i]; y = m_y[i]; dx = m_dx[i]; dy = m_dy[i]; dv = m_div[i];
      ar = m_ar[i]; xd = m_xd[i]; yd = m_yd[i]; b1 = 0; b2 = 0; stp = 0;
      if (!rst_n) begin
        x = 320; y = 240; dx = 1; dy = 1; dv = 0; ar = 0; xd = 0; yd = 0;
      end else begin
        if (tk && run) begin
          if (dv == fd[i] - 1) begin dv = 0; stp = 1; end
          else dv = dv + 1;
        end
        if (serve) begin
          x = 320; y = 240; dx = 1; dy = 1; dv = 0; ar = int'(run); xd = 0; yd = 0;
        end else if (xd != 0) begin
          move(x, dx, int'(sx), XM, x, dx, b1);
          xd = 0; yd = 1;
        end else if (yd != 0) begin
          move(y, dy, int'(sy), YM, y, dy, b2);
          yd = 0; ar = int'(run);
        end else if (ar != 0) begin
          if (stp) xd = 1;
          else if (!run) ar = 0;
        end else begin
          ar = int'(run);
        end
      end
      m_x[i] <= x; m_y[i] <= y; m_dx[i] <= dx; m_dy[i] <= dy; m_div[i] <= dv;
      m_ar[i] <= ar; m_xd[i] <= xd; m_yd[i] <= yd; m_bx[i] <= b1; m_by[i] <= b2;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("x%0d", i), int'(px[i]), m_x[i]);
        check($sformatf("y%0d", i), int'(py[i]), m_y[i]);
        check($sformatf("bx%0d", i), int'(bx[i]), m_bx[i]);
        check($sformatf("by%0d", i), int'(by[i]), m_by[i]);
      end
    end
  end

  // 12-cycle frames: five blanking cycles at line 480, then seven active lines
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      ypos = (fc < 5) ? 10'd480 : 10'(fc - 5);
      fc = (fc + 1) % 12;
    end
  endtask

  task automatic frames(input int n);
    cycles(12 * n);
  endtask

  task automatic align();
    while (fc != 0) cycles(1);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; serve = 1'b0; sx = 3'd0; sy = 3'd0; ypos = 10'd0;
    cycles(3);
    chk_en = 1'b1;
    rst_n = 1'b1;
    frames(3);
    check("rst_x0", int'(px[0]), 320);
    check("rst_y0", int'(py[0]), 240);
    check("rst_x1", int'(px[1]), 320);

    // Basic motion, speed 2/1, four ticks
    align();
    sx = 3'd2; sy = 3'd1; run = 1'b1;
    frames(4);
    check("mv_x0", int'(px[0]), 328);
    check("mv_y0", int'(py[0]), 244);
    check("mv_x1", int'(px[1]), 322);
    check("mv_y1", int'(py[1]), 241);

    // Right wall approach from a fresh serve
    run = 1'b0;
    frames(1);
    serve = 1'b1; cycles(1); serve = 1'b0;
    sx = 3'd3; sy = 3'd0; run = 1'b1;
    align();
    frames(104);
    check("wall_pre", int'(px[0]), 632);
    frames(1);
    check("wall_hit", int'(px[0]), 634);
    frames(1);
    check("wall_back", int'(px[0]), 631);
    check("wall_y", int'(py[0]), 240);

    // serve coinciding with a step-issuing tick
    align();
    cycles(1);
    serve = 1'b1; cycles(1); serve = 1'b0;
    cycles(10);
    check("srv_x", int'(px[0]), 320);
    check("srv_y", int'(py[0]), 240);
    frames(1);
    check("post_srv_x", int'(px[0]), 323);

    // reset while STEP_X is executing
    align();
    cycles(2);
    rst_n = 1'b0; cycles(1); rst_n = 1'b1;
    check("rst_step_x", int'(px[0]), 320);
    cycles(10);

    // Randomized operation
    for (int c = 0; c < 4800; c++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) sx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) sy = 3'($urandom_range(0, 7));
      serve = ($urandom_range(0, 199) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      cycles(1);
    end
    serve = 1'b0; rst_n = 1'b1;
    cycles(4);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
